// File: rtl/move_request_arbiter_pkg.sv
// Shared constants for the move request arbiter: direction indices and FSM state encoding.
package move_pkg;

  localparam int unsigned NUM_DIR_DEF = 4;
  localparam int unsigned DIR_W       = $clog2(NUM_DIR_DEF);

  localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd1;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd2;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OFFER    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

endpackage

// File: rtl/move_request_arbiter_hold_repeat_timer.sv
// Per-direction press-edge detector and hold auto-repeat timer.
// 'edge' is a reserved word, so the press-edge output is named press_edge.
module hold_repeat_timer #(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 6_250_000,
  parameter int unsigned CNT_W         = 25
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic level,
  input  logic clear,
  output logic press_edge,
  output logic tick
);

  logic             prev_q;
  logic             rep_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] target;

  assign press_edge = level & ~prev_q;
  assign target     = rep_q ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY);
  // cnt_q equals the number of held cycles since the press edge (or last tick)
  assign tick       = (REPEAT_DELAY != 0) && level && !press_edge && !clear && (cnt_q == target);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      prev_q <= 1'b0;
      rep_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= level;
      if (clear || !level) begin
        cnt_q <= '0;
        rep_q <= 1'b0;
      end else if (press_edge) begin
        cnt_q <= CNT_W'(1);
        rep_q <= 1'b0;
      end else if (tick) begin
        cnt_q <= CNT_W'(1);
        rep_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/move_request_arbiter.sv
// Converts debounced direction switches into single move commands: edge/repeat events latch
// into pending flags, a round-robin arbiter picks one, and a valid/ready offer plus cooldown follows.
module move_request_arbiter
  import move_pkg::*;
#(
  parameter int unsigned NUM_DIR         = 4,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 6_250_000,
  parameter int unsigned COOLDOWN_CYCLES = 1_250_000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_n,
  input  logic                       i_Enable,
  input  logic [NUM_DIR-1:0]         i_Switch,
  input  logic                       i_Move_Ready,
  output logic                       o_Move_Valid,
  output logic [$clog2(NUM_DIR)-1:0] o_Move_Dir,
  output logic [NUM_DIR-1:0]         o_Pending,
  output logic                       o_Busy
);

  localparam int unsigned DW = $clog2(NUM_DIR);

  state_t             state_q, state_d;
  logic               first_q;
  logic [NUM_DIR-1:0] pend_q;
  logic [DW-1:0]      rr_q;
  logic [DW-1:0]      dir_q;
  logic [CNT_W-1:0]   cd_q;
  logic [NUM_DIR-1:0] edges, ticks, evt, clr_mask;
  logic [DW-1:0]      pick_dir;
  logic               handshake, any_pend, timer_clr;

  assign timer_clr = ~i_Enable;

  for (genvar k = 0; k < NUM_DIR; k++) begin : g_dir
    hold_repeat_timer #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CNT_W        (CNT_W)
    ) u_timer (
      .i_Clk     (i_Clk),
      .i_Rst_n   (i_Rst_n),
      .level     (i_Switch[k]),
      .clear     (timer_clr),
      .press_edge(edges[k]),
      .tick      (ticks[k])
    );
  end

  // The first cycle after reset only loads prev-switch, so a switch held through reset is not a press
  assign evt       = (edges | ticks) & {NUM_DIR{i_Enable & ~first_q}};
  assign any_pend  = |pend_q;
  assign handshake = (state_q == ST_OFFER) && i_Move_Ready;

  // Rotating priority encoder: first pending bit at or after rr_q, wrapping
  always_comb begin
    int unsigned idx;
    logic        found;
    pick_dir = rr_q;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NUM_DIR) idx = idx - NUM_DIR;
      if (!found && pend_q[idx[DW-1:0]]) begin
        pick_dir = idx[DW-1:0];
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    clr_mask = '0;
    if (handshake) clr_mask[dir_q] = 1'b1;
  end

  // Set wins over clear so an event coinciding with service still leaves a move queued
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)       pend_q <= '0;
    else if (!i_Enable) pend_q <= '0;
    else                pend_q <= (pend_q & ~clr_mask) | evt;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (any_pend) state_d = ST_OFFER;
      ST_OFFER:    if (i_Move_Ready) state_d = (COOLDOWN_CYCLES == 0) ? ST_IDLE : ST_COOLDOWN;
      ST_COOLDOWN: if (cd_q <= CNT_W'(1)) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      first_q <= 1'b1;
      dir_q   <= '0;
      rr_q    <= '0;
      cd_q    <= '0;
    end else begin
      first_q <= 1'b0;
      if (state_q == ST_IDLE && any_pend) dir_q <= pick_dir;
      if (handshake) begin
        rr_q <= (32'(dir_q) == NUM_DIR - 1) ? '0 : dir_q + DW'(1);
        cd_q <= CNT_W'(COOLDOWN_CYCLES);
      end else if (state_q == ST_COOLDOWN) begin
        cd_q <= cd_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    o_Move_Valid = (state_q == ST_OFFER);
    o_Busy       = (state_q != ST_IDLE);
    o_Move_Dir   = dir_q;
    o_Pending    = pend_q;
  end

endmodule

// File: tb/tb_move_request_arbiter.sv
// Directed bench for move_request_arbiter with short repeat/cooldown timing.
module tb_move_request_arbiter;
  import move_pkg::*;

  logic       clk, rst_n, en, rdy;
  logic [3:0] sw;
  logic       valid, busy;
  logic [1:0] dir;
  logic [3:0] pend;

  int checks = 0;
  int errors = 0;

  move_request_arbiter #(
    .NUM_DIR        (4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (4),
    .COOLDOWN_CYCLES(3),
    .CNT_W          (8)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Enable    (en),
    .i_Switch    (sw),
    .i_Move_Ready(rdy),
    .o_Move_Valid(valid),
    .o_Move_Dir  (dir),
    .o_Pending   (pend),
    .o_Busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    logic       exp_valid;
    logic [1:0] exp_dir;
    logic [3:0] exp_pend;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    int n;
    n = 0;
    while (!valid && n < max_cyc) begin
      step();
      n++;
    end
    chk({name, "_seen"}, 32'(valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_v, n_moves;

    // single press, then a 1/3 tie, then a re-press forming a tie with rr pointer at 2
    tbl[0]  = '{4'b0001, 1'b0, DIR_UP,    4'b0001, 1'b0};
    tbl[1]  = '{4'b0001, 1'b1, DIR_UP,    4'b0001, 1'b1};
    tbl[2]  = '{4'b0001, 1'b0, DIR_UP,    4'b0000, 1'b1};
    tbl[3]  = '{4'b0000, 1'b0, DIR_UP,    4'b0000, 1'b1};
    tbl[4]  = '{4'b0000, 1'b0, DIR_UP,    4'b0000, 1'b1};
    tbl[5]  = '{4'b0000, 1'b0, DIR_UP,    4'b0000, 1'b0};
    tbl[6]  = '{4'b1010, 1'b0, DIR_UP,    4'b1010, 1'b0};
    tbl[7]  = '{4'b1010, 1'b1, DIR_DOWN,  4'b1010, 1'b1};
    tbl[8]  = '{4'b0000, 1'b0, DIR_DOWN,  4'b1000, 1'b1};
    tbl[9]  = '{4'b0010, 1'b0, DIR_DOWN,  4'b1010, 1'b1};
    tbl[10] = '{4'b0000, 1'b0, DIR_DOWN,  4'b1010, 1'b1};
    tbl[11] = '{4'b0000, 1'b0, DIR_DOWN,  4'b1010, 1'b0};
    tbl[12] = '{4'b0000, 1'b1, DIR_RIGHT, 4'b1010, 1'b1};
    tbl[13] = '{4'b0000, 1'b0, DIR_RIGHT, 4'b0010, 1'b1};
    tbl[14] = '{4'b0000, 1'b0, DIR_RIGHT, 4'b0010, 1'b1};
    tbl[15] = '{4'b0000, 1'b0, DIR_RIGHT, 4'b0010, 1'b1};
    tbl[16] = '{4'b0000, 1'b0, DIR_RIGHT, 4'b0010, 1'b0};
    tbl[17] = '{4'b0000, 1'b1, DIR_DOWN,  4'b0010, 1'b1};
    tbl[18] = '{4'b0000, 1'b0, DIR_DOWN,  4'b0000, 1'b1};
    tbl[19] = '{4'b0000, 1'b0, DIR_DOWN,  4'b0000, 1'b1};
    tbl[20] = '{4'b0000, 1'b0, DIR_DOWN,  4'b0000, 1'b1};
    tbl[21] = '{4'b0000, 1'b0, DIR_DOWN,  4'b0000, 1'b0};

    rst_n = 1'b0; en = 1'b1; rdy = 1'b1; sw = 4'b0000;
    step(); step();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_dir",   32'(dir),   32'd0);
    chk("rst_pend",  32'(pend),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    rst_n = 1'b1;
    step(); step();

    for (int i = 0; i < 22; i++) begin
      sw = tbl[i].sw;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_dir", i),   32'(dir),   32'(tbl[i].exp_dir));
      chk($sformatf("tbl%0d_pend", i),  32'(pend),  32'(tbl[i].exp_pend));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),  32'(tbl[i].exp_busy));
    end

    // hold RIGHT for 30 cycles: press move, repeats at 8, 12, 16, 20, 24, 28 gated by cooldown
    n_moves = 0;
    for (int h = 0; h < 41; h++) begin
      sw = (h < 30) ? 4'b1000 : 4'b0000;
      step();
      exp_v = (h == 1 || h == 9 || h == 14 || h == 19 || h == 24 || h == 29) ? 1 : 0;
      chk($sformatf("hold_valid_h%0d", h), 32'(valid), 32'(exp_v));
      if (exp_v != 0) chk($sformatf("hold_dir_h%0d", h), 32'(dir), 32'(DIR_RIGHT));
      n_moves += int'(valid);
    end
    chk("hold_moves", 32'(n_moves), 32'd6);
    chk("hold_pend_end", 32'(pend), 32'd0);

    // consumer stalls for 20 cycles while new presses arrive
    rdy = 1'b0; sw = 4'b0001;
    step();
    sw = 4'b0000;
    for (int i = 1; i <= 20; i++) begin
      sw = (i == 5) ? 4'b0110 : 4'b0000;
      step();
      chk($sformatf("stall_valid_%0d", i), 32'(valid), 32'd1);
      chk($sformatf("stall_dir_%0d", i),   32'(dir),   32'(DIR_UP));
      if (i == 8) chk("stall_pend", 32'(pend), 32'b0111);
    end
    rdy = 1'b1;
    step();
    chk("stall_accept_valid", 32'(valid), 32'd0);
    chk("stall_accept_pend",  32'(pend),  32'b0110);
    wait_valid("stall_next1", 20);
    chk("stall_next1_dir", 32'(dir), 32'(DIR_DOWN));
    step();
    wait_valid("stall_next2", 20);
    chk("stall_next2_dir", 32'(dir), 32'(DIR_LEFT));
    step();
    repeat (5) step();

    // switch held through reset makes no move
    sw = 4'b0100; rst_n = 1'b0;
    step(); step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rsthold_valid_%0d", i), 32'(valid), 32'd0);
      chk($sformatf("rsthold_pend_%0d", i),  32'(pend),  32'd0);
    end
    sw = 4'b0000;
    step(); step();
    sw = 4'b0100;
    wait_valid("repress", 10);
    chk("repress_dir", 32'(dir), 32'(DIR_LEFT));
    step();
    sw = 4'b0000;
    n_moves = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_moves += int'(valid);
    end
    chk("repress_single", 32'(n_moves), 32'd0);

    // disable clears pending, ignores presses, in-flight offer still completes
    rdy = 1'b0; sw = 4'b0001;
    step();
    sw = 4'b0000;
    step();
    chk("dis_offer_valid", 32'(valid), 32'd1);
    chk("dis_offer_dir",   32'(dir),   32'(DIR_UP));
    sw = 4'b1010;
    step();
    sw = 4'b0000;
    chk("dis_pend_before", 32'(pend), 32'b1011);
    en = 1'b0;
    step();
    chk("dis_pend_clr",   32'(pend),  32'd0);
    chk("dis_hold_valid", 32'(valid), 32'd1);
    chk("dis_hold_dir",   32'(dir),   32'(DIR_UP));
    sw = 4'b0100;
    step(); step();
    chk("dis_press_ignored", 32'(pend), 32'd0);
    rdy = 1'b1;
    step();
    chk("dis_accept_valid", 32'(valid), 32'd0);
    sw = 4'b0000;
    step();
    en = 1'b1;
    n_moves = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_moves += int'(valid) + int'(pend != 4'b0000);
    end
    chk("dis_no_moves", 32'(n_moves), 32'd0);

    // asynchronous reset in the middle of an offer
    rdy = 1'b0; sw = 4'b0001;
    step();
    sw = 4'b0000;
    step();
    chk("arst_pre_valid", 32'(valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_busy",  32'(busy),  32'd0);
    chk("arst_pend",  32'(pend),  32'd0);
    step();
    rst_n = 1'b1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
